// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC generation, imem requests, instruction buffer
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/addr/ready         fetch request to instruction memory (word-aligned byte address)
//   imem_resp_valid/data              in-order instruction words returned by imem
//   redirect_valid/pc                 taken branch/jump target from EX; flushes buffered and in-flight fetches
//   if_valid/instr/pc/ready           head of the instruction buffer towards decode
//   perf_fetch_cnt, perf_drop_cnt     only with FETCH_PERF_EN: decode handshakes / discarded responses
//
// Optional feature macro: FETCH_PERF_EN
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_drop_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {FETCH, FLUSH} state_t;

   state_t          state, state_nxt;
   logic [31:0]     pc;
   logic            started;
   logic [CW-1:0]   outstanding, drop_cnt, fifo_count, drop_reload;
   logic [AW-1:0]   tag_wr, tag_rd, fifo_wr, fifo_rd;
   logic [31:0]     tag_q      [FIFO_DEPTH];
   logic [31:0]     fifo_instr [FIFO_DEPTH];
   logic [31:0]     fifo_pc    [FIFO_DEPTH];
   logic [CW:0]     credit_used;
   logic            req_fire, resp, resp_drop, fifo_push, fifo_pop, fifo_nonempty;

   // Every in-flight request owns a buffer slot, so a response can always be absorbed.
   assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = started & ~rst & ~redirect_valid & (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign resp           = imem_resp_valid;
   assign resp_drop      = resp & (redirect_valid | (state == FLUSH));
   assign fifo_push      = resp & ~resp_drop;
   assign drop_reload    = outstanding - CW'(resp);

   assign fifo_nonempty  = (fifo_count != '0);
   assign if_valid       = fifo_nonempty & ~redirect_valid & ~rst;
   assign fifo_pop       = if_valid & if_ready;
   assign if_instr       = (fifo_nonempty & ~rst) ? fifo_instr[fifo_rd] : 32'h0;
   assign if_pc          = (fifo_nonempty & ~rst) ? fifo_pc[fifo_rd]    : 32'h0;

   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = (drop_reload != '0) ? FLUSH : FETCH;
      end else if (state == FLUSH && resp && drop_cnt == CW'(1)) begin
         state_nxt = FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         started     <= 1'b0;
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
         fifo_wr     <= '0;
         fifo_rd     <= '0;
         fifo_count  <= '0;
      end else begin
         state       <= state_nxt;
         started     <= 1'b1;
         outstanding <= outstanding + CW'(req_fire) - CW'(resp);
         if (redirect_valid) pc <= {redirect_pc[31:2], 2'b00};
         else if (req_fire)  pc <= pc + 32'd4;
         if (req_fire) tag_wr <= tag_wr + 1'b1;
         if (resp)     tag_rd <= tag_rd + 1'b1;
         if (redirect_valid)                 drop_cnt <= drop_reload;
         else if (state == FLUSH && resp)    drop_cnt <= drop_cnt - CW'(1);
         if (redirect_valid) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
         end else begin
            if (fifo_push) fifo_wr <= fifo_wr + 1'b1;
            if (fifo_pop)  fifo_rd <= fifo_rd + 1'b1;
            fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
         end
      end
   end

   // Storage arrays carry no reset; validity is tracked by the pointers and counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (req_fire) tag_q[tag_wr] <= pc;
         if (fifo_push) begin
            fifo_instr[fifo_wr] <= imem_resp_data;
            fifo_pc[fifo_wr]    <= tag_q[tag_rd];
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= 32'h0;
         perf_drop_cnt  <= 32'h0;
      end else begin
         perf_fetch_cnt <= perf_fetch_cnt + 32'(fifo_pop);
         perf_drop_cnt  <= perf_drop_cnt + 32'(resp_drop);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (resp) assert (outstanding != '0);
         if (req_fire) assert (outstanding != CW'(FIFO_DEPTH));
         if (fifo_push && !fifo_pop) assert (fifo_count != CW'(FIFO_DEPTH));
         if (state == FLUSH && resp && !redirect_valid) assert (drop_cnt != '0);
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready = 1'b0;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

   instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
`ifdef FETCH_PERF_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } req_t;

   // Model: requests in flight tagged with the redirect epoch they were issued in;
   // a response is kept only if its epoch is still current.
   req_t        q[$];
   logic [31:0] mf[$];
   logic [31:0] m_pc;
   bit          started;
   int          m_epoch;
   int          cyc, lat;
   int          nerr, nchk;
   logic [31:0] fire_log[$];
   logic [31:0] hs_log[$];
   int          first_fire, first_ifv;
   int          m_fetch, m_drop;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
   endfunction

   function automatic logic [31:0] fire_at(input int i);
      return (i < fire_log.size()) ? fire_log[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] hs_at(input int i);
      return (i < hs_log.size()) ? hs_log[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_log();
      fire_log.delete();
      hs_log.delete();
      first_fire = -1;
      first_ifv  = -1;
   endtask

   task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc,
                       input bit ir, input bit resp_en);
      bit   rsp, exp_req, exp_ifv, fire, pop;
      req_t e;
      rst            = r;
      imem_req_ready = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if_ready       = ir;
      rsp = !r && resp_en && q.size() > 0;
      if (rsp) rsp = (q[0].due <= cyc);
      imem_resp_valid = rsp;
      if (rsp) imem_resp_data = mem_word(q[0].addr);
      else     imem_resp_data = $urandom;
      @(negedge clk);
      exp_req = !r && started && !rv && (q.size() + mf.size() < DEPTH);
      exp_ifv = !r && mf.size() > 0 && !rv;
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
      if (!r) chk("req_addr", imem_req_addr, m_pc);
      chk("if_valid", {31'b0, if_valid}, {31'b0, exp_ifv});
      chk("if_pc", if_pc, (!r && mf.size() > 0) ? mf[0] : 32'h0);
      chk("if_instr", if_instr, (!r && mf.size() > 0) ? mem_word(mf[0]) : 32'h0);
`ifdef FETCH_PERF_EN
      if (!r && started) begin
         chk("perf_fetch", perf_fetch_cnt, m_fetch);
         chk("perf_drop", perf_drop_cnt, m_drop);
      end
`endif
      if (r) begin
         m_pc = RESET_PC;
         mf.delete();
         q.delete();
         started = 0;
         m_fetch = 0;
         m_drop  = 0;
      end else begin
         fire = exp_req && rdy;
         pop  = exp_ifv && ir;
         if (exp_ifv && first_ifv < 0) first_ifv = cyc;
         if (pop) begin
            hs_log.push_back(mf[0]);
            void'(mf.pop_front());
            m_fetch++;
         end
         if (rsp) begin
            e = q.pop_front();
            if (!rv && e.epoch == m_epoch) mf.push_back(e.addr);
            else m_drop++;
         end
         if (rv) begin
            mf.delete();
            m_epoch++;
            m_pc = {rpc[31:2], 2'b00};
         end
         if (fire) begin
            q.push_back('{m_pc, cyc + lat, m_epoch});
            fire_log.push_back(m_pc);
            if (first_fire < 0) first_fire = cyc;
            m_pc = m_pc + 32'd4;
         end
         started = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      clear_log();
   endtask

   initial begin
      nerr = 0; nchk = 0; cyc = 0; lat = 1; m_epoch = 0;
      m_pc = RESET_PC; started = 0; m_fetch = 0; m_drop = 0;
      clear_log();
      @(posedge clk);
      #1;

      // Streaming with 1-cycle imem latency; addresses wrap past 2^32.
      do_reset();
      repeat (10) step(0, 1, 0, 0, 1, 1);
      chk("a_fire0", fire_at(0), 32'hFFFF_FFF8);
      chk("a_fire1", fire_at(1), 32'hFFFF_FFFC);
      chk("a_fire2", fire_at(2), 32'h0000_0000);
      chk("a_hs0", hs_at(0), 32'hFFFF_FFF8);
      chk("a_hs1", hs_at(1), 32'hFFFF_FFFC);
      chk("a_hs2", hs_at(2), 32'h0000_0000);
      chk("a_latency", first_ifv - first_fire, 2);

      // Decode stalled: credit limits fires to the buffer depth.
      do_reset();
      repeat (10) step(0, 1, 0, 0, 0, 1);
      chk("b_fires", fire_log.size(), DEPTH);
      chk("b_req_valid", {31'b0, imem_req_valid}, 32'h0);
      repeat (6) step(0, 1, 0, 0, 1, 1);
      chk("b_hs0", hs_at(0), 32'hFFFF_FFF8);
      chk("b_hs1", hs_at(1), 32'hFFFF_FFFC);

      // Redirect with two in flight: both responses dropped, fetch resumes at aligned target.
      do_reset();
      repeat (4) step(0, 1, 0, 0, 1, 0);
      chk("c_inflight", fire_log.size(), 2);
      step(0, 1, 1, 32'h0000_0103, 1, 0);
      clear_log();
      repeat (8) step(0, 1, 0, 0, 1, 1);
      chk("c_fire0", fire_at(0), 32'h0000_0100);
      chk("c_hs0", hs_at(0), 32'h0000_0100);

      // Redirect coinciding with the only response.
      do_reset();
      step(0, 1, 0, 0, 1, 0);
      step(0, 1, 0, 0, 1, 0);
      step(0, 0, 1, 32'h0000_0200, 1, 1);
      clear_log();
      repeat (6) step(0, 1, 0, 0, 1, 1);
      chk("d_fire0", fire_at(0), 32'h0000_0200);
      chk("d_hs0", hs_at(0), 32'h0000_0200);

      // Reset while flushing.
      do_reset();
      repeat (3) step(0, 1, 0, 0, 1, 0);
      step(0, 1, 1, 32'h0000_0300, 1, 0);
      step(0, 1, 0, 0, 1, 1);
      step(1, 1, 0, 0, 1, 0);
      step(0, 1, 0, 0, 1, 0);
      chk("e_pc", imem_req_addr, RESET_PC);
      chk("e_if_valid", {31'b0, if_valid}, 32'h0);

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         lat = $urandom_range(1, 3);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
              $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
